// File: rtl/shadow_ret_stack.sv
// Shadow return-address stack: circular LIFO of 32-bit addresses with sticky overflow/underflow flags.
// Define SHADOW_RET_STACK_WRAP_EN to make a push while full overwrite the oldest entry instead of being dropped.
module shadow_ret_stack #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_en,
    input  logic              st_push_pop,
    input  logic [31:0]       st_data_in,
    output logic [31:0]       st_data_out,
    output logic              stack_empty,
    output logic              stack_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] top_m1;
    logic [ADDR_W:0]   cnt;
    logic              is_full;
    logic              is_empty;
    logic              do_push;
    logic              do_pop;
    logic              wr_en;

    assign is_full     = (cnt == (ADDR_W+1)'(DEPTH));
    assign is_empty    = (cnt == '0);
    assign top_m1      = top - ADDR_W'(1);
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign count       = cnt;

    always_comb begin
        do_push = st_en && st_push_pop;
        do_pop  = st_en && !st_push_pop;
`ifdef SHADOW_RET_STACK_WRAP_EN
        // When full, the slot at top holds the oldest entry, so writing it overwrites the oldest.
        wr_en   = do_push;
`else
        wr_en   = do_push && !is_full;
`endif
    end

    // Array is intentionally not reset; count=0 makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[top] <= st_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top         <= '0;
            cnt         <= '0;
            st_data_out <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_en)
                top <= top + ADDR_W'(1);
            if (do_push && !is_full)
                cnt <= cnt + (ADDR_W+1)'(1);
            if (do_push && is_full)
                overflow <= 1'b1;
            if (do_pop) begin
                if (is_empty) begin
                    st_data_out <= '0;
                    underflow   <= 1'b1;
                end else begin
                    st_data_out <= mem[top_m1];
                    top         <= top_m1;
                    cnt         <= cnt - (ADDR_W+1)'(1);
                end
            end
        end
    end

endmodule

// File: doc/shadow_ret_stack.md
SHADOW_RET_STACK -- requirements
Module: shadow_ret_stack

Interface
REQ-001 Parameter DEPTH, 64: number of 32-bit return-address entries; SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_W, 6: pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 st_en  in  1  operation strobe from the monitor FSM; one operation per cycle while high.
REQ-006 st_push_pop  in  1  1 = push, 0 = pop; qualified by st_en.
REQ-007 st_data_in  in  32  return address to push.
REQ-008 st_data_out  out  32  registered popped address, returned to the FSM comparator.
REQ-009 stack_empty  out  1  high when count == 0.
REQ-010 stack_full  out  1  high when count == DEPTH.
REQ-011 count  out  ADDR_W+1  current number of valid entries.
REQ-012 overflow  out  1  sticky: push attempted while full.
REQ-013 underflow  out  1  sticky: pop attempted while empty.

Function
REQ-014 Storage SHALL be a DEPTH x 32 array addressed by a circular top pointer `top` (next free slot, modulo DEPTH) plus count.
REQ-015 Push, not full (st_en=1, st_push_pop=1): mem[top] <= st_data_in; top <= top+1; count <= count+1; st_data_out unchanged.
REQ-016 Pop, not empty (st_en=1, st_push_pop=0): st_data_out <= mem[top-1]; top <= top-1; count <= count-1.
REQ-017 Pop latency SHALL be exactly one cycle: data is valid in the cycle after st_en is sampled and SHALL hold until the next pop or reset, so it is stable through the FSM's WAIT-to-CHECK window.
REQ-018 Pop while empty: top and count unchanged; st_data_out <= 0; underflow <= 1.
REQ-019 Push while full: behaviour per REQ-027/REQ-028; overflow <= 1 in both builds.
REQ-020 st_en=0: no state change; st_data_out SHALL hold its value.
REQ-021 stack_empty, stack_full and count SHALL be driven combinationally from registered state only, with no path from inputs.
REQ-022 overflow and underflow SHALL clear only on reset.
REQ-023 A push directly followed by a pop SHALL return the pushed value; back-to-back operations on consecutive cycles SHALL be supported with no bubble.

Reset
REQ-024 When reset is high at a clock edge, the following SHALL apply, including mid-operation and taking priority over st_en: top=0, count=0, st_data_out=0, overflow=0, underflow=0.
REQ-025 Array contents SHALL NOT be cleared; they are unreachable after reset because count=0.
REQ-026 In the first cycle after reset: stack_empty=1, stack_full=0.

Configuration
REQ-027 With macro SHADOW_RET_STACK_WRAP_EN defined, push while full SHALL overwrite the oldest entry: mem[top] <= st_data_in, top <= top+1, count held at DEPTH.
REQ-028 Without SHADOW_RET_STACK_WRAP_EN, push while full SHALL be dropped: array, top and count are unchanged.

Verification
REQ-029 Reset, then push 0x0000_1000, 0x0000_2000, then pop twice -> st_data_out = 0x2000, then 0x1000, each one cycle after the pop strobe; count goes 2,1,0; stack_empty=1 at end.
REQ-030 Pop on empty after reset -> st_data_out=0, underflow=1 and sticky, count=0; a later valid push/pop does not clear underflow.
REQ-031 DEPTH=4, push 0xA1..0xA5. Without WRAP_EN: overflow=1, count=4, pops return A4,A3,A2,A1. With WRAP_EN: pops return A5,A4,A3,A2.
REQ-032 Push 0xDEAD_BEEF, hold st_en=0 for 10 cycles, then pop -> st_data_out=0xDEADBEEF, and it stays stable for 3 further idle cycles.
REQ-033 Push 3 values, assert reset for 1 cycle coincident with a push strobe -> count=0, flags=0, st_data_out=0; a following pop gives underflow=1 and data 0.
REQ-034 Alternate push/pop every cycle for 64 cycles with incrementing data -> each pop returns the immediately prior push and count toggles between 0 and 1.
